// File: rtl/rr_addr_arbiter.sv
// rtl/rr_addr_arbiter.sv - four-way round-robin arbiter driving a 2-to-4 decoder's address/enable inputs
// Optional hold-timeout forced release is compiled in when ARB_TIMEOUT_EN is defined.
module rr_addr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_release,
  output logic       o_address0,
  output logic       o_address1,
  output logic       o_enable,
  output logic       o_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_addr;
  logic [1:0] w_addr_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic       r_enable;
  logic       w_enable_nxt;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_timeout;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_addr_arbiter: MAX_HOLD must be within 1..255");
  end

  // Scan from lowest priority (ptr itself) up to highest (ptr+1) so the last hit wins.
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (i_req[r_ptr + 2'(i)]) begin
        w_pick  = r_ptr + 2'(i);
        w_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;

  assign w_timeout = (r_hold == HOLD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= 8'd0;
    end else if (r_state == ST_GRANT && w_state_nxt == ST_GRANT) begin
      r_hold <= r_hold + 8'd1;
    end else begin
      r_hold <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_ptr_nxt    = r_ptr;
    w_enable_nxt = r_enable;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_GRANT;
          w_addr_nxt   = w_pick;
          w_ptr_nxt    = w_pick;
          w_enable_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        // Exiting always passes through IDLE, giving the decoder a one-cycle bubble.
        if (i_release || !i_req[r_addr] || w_timeout) begin
          w_state_nxt  = ST_IDLE;
          w_enable_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= 2'd0;
      r_ptr    <= 2'd3;
      r_enable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_ptr    <= w_ptr_nxt;
      r_enable <= w_enable_nxt;
    end
  end

  assign o_address0 = r_addr[0];
  assign o_address1 = r_addr[1];
  assign o_enable   = r_enable;
  assign o_busy     = r_enable;

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// tb/tb_rr_addr_arbiter.sv - self-checking bench for rr_addr_arbiter with a behavioural arbitration model
module tb_rr_addr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_TB    = 4;
  localparam bit          TIMEOUT_ON = 1'b1;
`else
  localparam int unsigned HOLD_TB    = 8;
  localparam bit          TIMEOUT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic       a0;
  logic       a1;
  logic       en;
  logic       busy;

  int checks;
  int errors;

  int m_addr;
  int m_ptr;
  int m_len;
  bit m_en;

  rr_addr_arbiter #(.MAX_HOLD(HOLD_TB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_release  (rel),
    .o_address0 (a0),
    .o_address1 (a1),
    .o_enable   (en),
    .o_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_addr = 0;
    m_ptr  = 3;
    m_len  = 0;
    m_en   = 1'b0;
  endtask

  // One rising edge of the arbitration rules, applied to the inputs present at that edge.
  task automatic model_clock(input logic [3:0] r, input logic rl);
    if (m_en) begin
      if (rl || !r[m_addr] || (TIMEOUT_ON && m_len >= int'(HOLD_TB))) m_en = 1'b0;
      else m_len++;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (r[c]) begin
          m_addr = c;
          m_ptr  = c;
          m_en   = 1'b1;
          m_len  = 1;
          break;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    model_clock(r, rl);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a1, a0, en, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000", {a1, a0, en, busy});
    end
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    checks++;
    if ({a1, a0} !== 2'd0 || en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got addr=%0d en=%b busy=%b want addr=0 en=1 busy=1", {a1, a0}, en, busy);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] seq [4];
    logic [1:0] prev;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
    prev = 2'd0;
    for (int g = 0; g < 4; g++) begin
      step(4'b1111, 1'b1);
      checks++;
      if (en !== 1'b0 || {a1, a0} !== prev) begin
        errors++;
        $display("FAIL rotation_bubble g=%0d got en=%b addr=%0d want en=0 addr=%0d", g, en, {a1, a0}, prev);
      end
      step(4'b1111, 1'b0);
      checks++;
      if (en !== 1'b1 || {a1, a0} !== seq[g]) begin
        errors++;
        $display("FAIL rotation_grant g=%0d got en=%b addr=%0d want en=1 addr=%0d", g, en, {a1, a0}, seq[g]);
      end
      prev = seq[g];
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (en !== 1'b0 || busy !== 1'b0 || {a1, a0} !== 2'd0) begin
        errors++;
        $display("FAIL idle_hold i=%0d got en=%b busy=%b addr=%0d want 0/0/0", i, en, busy, {a1, a0});
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    step(4'b0100, 1'b0);
    checks++;
    if (en !== 1'b1 || {a1, a0} !== 2'd2) begin
      errors++;
      $display("FAIL drop_grant2 got en=%b addr=%0d want en=1 addr=2", en, {a1, a0});
    end
    step(4'b1001, 1'b0);
    checks++;
    if (en !== 1'b0 || {a1, a0} !== 2'd2) begin
      errors++;
      $display("FAIL drop_exit got en=%b addr=%0d want en=0 addr=2", en, {a1, a0});
    end
    step(4'b1001, 1'b0);
    checks++;
    if (en !== 1'b1 || {a1, a0} !== 2'd3) begin
      errors++;
      $display("FAIL drop_next got en=%b addr=%0d want en=1 addr=3", en, {a1, a0});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0010, 1'b0);
    checks++;
    if (en !== 1'b1 || {a1, a0} !== 2'd1) begin
      errors++;
      $display("FAIL async_pre got en=%b addr=%0d want en=1 addr=1", en, {a1, a0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a1, a0, en, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b want=0000", {a1, a0, en, busy});
    end
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    checks++;
    if (en !== 1'b1 || {a1, a0} !== 2'd0) begin
      errors++;
      $display("FAIL async_restart got en=%b addr=%0d want en=1 addr=0", en, {a1, a0});
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b1);
    checks++;
    if (en !== 1'b0 || {a1, a0} !== 2'd0) begin
      errors++;
      $display("FAIL same_edge_bubble got en=%b addr=%0d want en=0 addr=0", en, {a1, a0});
    end
    step(4'b0011, 1'b0);
    checks++;
    if (en !== 1'b1 || {a1, a0} !== 2'd1) begin
      errors++;
      $display("FAIL same_edge_grant got en=%b addr=%0d want en=1 addr=1", en, {a1, a0});
    end
  endtask

  task automatic test_hold();
    logic exp_en;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(4'b0100, 1'b0);
      exp_en = TIMEOUT_ON ? ((k % int'(HOLD_TB + 1)) != 0) : 1'b1;
      checks++;
      if (en !== exp_en || {a1, a0} !== 2'd2) begin
        errors++;
        $display("FAIL hold k=%0d got en=%b addr=%0d want en=%b addr=2", k, en, {a1, a0}, exp_en);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rl;
    do_reset();
    r = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rl = ($urandom_range(0, 5) == 0);
      step(r, rl);
      checks++;
      if ({a1, a0} !== 2'(m_addr) || en !== m_en || busy !== m_en) begin
        errors++;
        $display("FAIL random i=%0d req=%b rel=%b got addr=%0d en=%b busy=%b want addr=%0d en=%b",
                 i, r, rl, {a1, a0}, en, busy, m_addr, m_en);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_rotation();
    test_idle_hold();
    test_drop();
    test_async_reset();
    test_same_edge();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_addr_arbiter.md
Name: rr_addr_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 structural decoder.
- Produces the decoder's address0/address1/enable inputs, so the decoder's out0..out3 become one-hot grant lines.
- Sequential: registered grant address, grant/idle state machine, rotating priority pointer, optional hold-timeout counter.
- All outputs come straight from flops, so the decoder's gate-delay paths see clean, edge-aligned inputs.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before a forced release. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; req[i] asks for grant i.
- release  input  1  one-cycle pulse from the current grantee; ends its grant.
- address0  output  1  grant index bit 0; drives decoder address0.
- address1  output  1  grant index bit 1; drives decoder address1.
- enable  output  1  grant valid; drives decoder enable.
- busy  output  1  high while in GRANT state; equals enable.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - address0=0, address1=0, enable=0, busy=0.
  - State=IDLE, priority pointer ptr=3 (so requester 0 has top priority first), hold counter=0.
- Grant index {address1,address0}: unsigned 2-bit. ptr is 2-bit and wraps mod 4.
- IDLE:
  - If req != 0 at a rising edge, choose the first set bit in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On that same edge: address <= chosen index, enable <= 1, ptr <= chosen index, state <= GRANT.
  - Latency: request sampled at edge N, grant visible after edge N. One cycle from request to enable.
  - If req == 0, outputs hold; address keeps its last value and enable stays 0.
  - release while IDLE is ignored.
- GRANT:
  - address held stable for the entire grant.
  - Exit condition: release=1, or req[address]=0 (grantee dropped its request).
  - On exit: enable <= 0, state <= IDLE. address keeps its value during the idle cycle.
  - Mandatory one-cycle bubble between grants, so the decoder can never show two outputs high across a grant change.
  - Next arbitration happens at the following edge.
  - New or other requests arriving while in GRANT wait; there is no preemption.
  - release and a new req on the same edge: release takes effect first; the new req is arbitrated from IDLE next cycle.
- Fairness: the just-served index becomes lowest priority. A requester held high waits at most 3 grants.
- Reset deasserting while req is already high: first grant occurs at the first rising edge after rst_n=1, and goes to the lowest set index.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD, a forced exit happens, identical to a release: enable is high for exactly MAX_HOLD cycles.
  - A release before the limit exits normally and clears the counter.
- Not defined:
  - No counter logic is synthesized.
  - A grant lasts until release or until the grantee drops its request, with no limit.

Test Plan:
- Reset with rst_n=0, req=4'b1111 -> all outputs 0. After rst_n rises, first edge gives address=0, enable=1.
- req=4'b1111 held, release pulsed once per grant -> grant sequence 0,1,2,3,0. Each grant separated by exactly one cycle with enable=0.
- Grant to index 2 active, then req[2] dropped with no release -> enable=0 on the next edge. With req=4'b1001, the following grant goes to index 3.
- Assert rst_n=0 mid-grant (address=1, enable=1) -> enable and address go to 0 immediately, without waiting for clk. After release of reset, priority restarts at index 0.
- Same edge: release=1 and req goes from 4'b0001 to 4'b0011 (grant at 0) -> one idle cycle, then address=1, enable=1.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0100 held, no release -> enable high for exactly 4 cycles, low for 1, then index 2 is re-granted. Without the macro, enable stays high indefinitely.
